// File: rtl/td4_loader_pkg.sv
// Shared constants, state encodings and the ASCII-hex decoder for the TD4 serial loader.
package td4_loader_pkg;

  localparam logic [7:0] CH_AT = 8'h40;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  typedef enum logic [1:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    P_IDLE,
    P_HI,
    P_LO
  } parse_state_t;

  // Returns {valid, nibble}. The low ASCII nibble of 'A'-'F' and 'a'-'f' is 1..6,
  // so adding 9 yields 10..15 without needing the upper bits of the character.
  function automatic logic [4:0] hex_val(input logic [7:0] ch);
    logic [4:0] r;
    r = 5'd0;
    if (ch >= 8'h30 && ch <= 8'h39) begin
      r = {1'b1, ch[3:0]};
    end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
      r = {1'b1, ch[3:0] + 4'd9};
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling, one-cycle byte/framing-error pulses.
module uart_rx_core
  import td4_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ferr
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic            rx_s1;
  logic            rx_s2;
  logic            rx_prev;
  rx_state_t       state;
  rx_state_t       state_nx;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            tick;
  logic            half_tick;

  assign tick      = (cnt == FULL_LAST);
  assign half_tick = (cnt == HALF_LAST);
  assign rx_data   = shreg;

  // Synchronize the asynchronous pin; rx_prev lets idle detect a falling edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // Receiver state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= R_IDLE;
    else          state <= state_nx;
  end

  // Receiver next-state: half-bit check of the start bit, then full-bit spacing.
  always_comb begin
    state_nx = state;
    unique case (state)
      R_IDLE:  if (rx_prev && !rx_s2) state_nx = R_START;
      R_START: if (half_tick) state_nx = rx_s2 ? R_IDLE : R_DATA;
      R_DATA:  if (tick && bit_idx == 3'd7) state_nx = R_STOP;
      R_STOP:  if (tick) state_nx = R_IDLE;
      default: state_nx = R_IDLE;
    endcase
  end

  // Bit timer, bit index, LSB-first shift register and registered result pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      bit_idx  <= 3'd0;
      shreg    <= 8'd0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      if (state == R_IDLE || state_nx != state || tick) cnt <= '0;
      else                                               cnt <= cnt + 1'b1;
      if (state == R_START)            bit_idx <= 3'd0;
      else if (state == R_DATA && tick) bit_idx <= bit_idx + 3'd1;
      if (state == R_DATA && tick) shreg <= {rx_s2, shreg[7:1]};
      rx_valid <= (state == R_STOP) && tick && rx_s2;
      rx_ferr  <= (state == R_STOP) && tick && !rx_s2;
    end
  end

endmodule

// File: rtl/td4_uart_loader.sv
// TD4 program loader: parses '@' followed by 16 ASCII-hex bytes into program-memory writes.
module td4_uart_loader
  import td4_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       fpga_rx,
  output logic       wr_en,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       cpu_hold,
  output logic       load_done,
  output logic       load_err
);

  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         rx_ferr;
  parse_state_t state;
  parse_state_t state_nx;
  logic [3:0]   addr;
  logic [3:0]   addr_nx;
  logic [3:0]   hi_nib;
  logic [3:0]   hi_nx;
  logic         wr_en_nx;
  logic [3:0]   wr_addr_nx;
  logic [7:0]   wr_data_nx;
  logic         hold_nx;
  logic         done_nx;
  logic         err_nx;
  logic [4:0]   hv;
  logic         fail;

  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clock    (clock),
    .reset_n  (reset_n),
    .rx       (fpga_rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr)
  );

  // Parser state and all registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= P_IDLE;
      addr      <= 4'd0;
      hi_nib    <= 4'd0;
      wr_en     <= 1'b0;
      wr_addr   <= 4'd0;
      wr_data   <= 8'd0;
      cpu_hold  <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      state     <= state_nx;
      addr      <= addr_nx;
      hi_nib    <= hi_nx;
      wr_en     <= wr_en_nx;
      wr_addr   <= wr_addr_nx;
      wr_data   <= wr_data_nx;
      cpu_hold  <= hold_nx;
      load_done <= done_nx;
      load_err  <= err_nx;
    end
  end

  // Parser next-state; cpu_hold drops the cycle after load_done so the last write lands first.
  always_comb begin
    state_nx   = state;
    addr_nx    = addr;
    hi_nx      = hi_nib;
    wr_en_nx   = 1'b0;
    wr_addr_nx = wr_addr;
    wr_data_nx = wr_data;
    done_nx    = 1'b0;
    err_nx     = load_err;
    hold_nx    = load_done ? 1'b0 : cpu_hold;
    hv         = hex_val(rx_data);
    fail       = 1'b0;
    if (rx_ferr) begin
      fail = (state != P_IDLE);
    end else if (rx_valid) begin
      unique case (state)
        P_IDLE: begin
          if (rx_data == CH_AT) begin
            state_nx = P_HI;
            addr_nx  = 4'd0;
            hold_nx  = 1'b1;
            err_nx   = 1'b0;
          end
        end
        P_HI: begin
          if (hv[4]) begin
            hi_nx    = hv[3:0];
            state_nx = P_LO;
          end else if (rx_data == CH_SP || rx_data == CH_CR || rx_data == CH_LF) begin
            state_nx = P_HI;
          end else if (rx_data == CH_AT) begin
            addr_nx = 4'd0;
          end else begin
            fail = 1'b1;
          end
        end
        P_LO: begin
          if (hv[4]) begin
            wr_en_nx   = 1'b1;
            wr_addr_nx = addr;
            wr_data_nx = {hi_nib, hv[3:0]};
            if (addr == 4'd15) begin
              done_nx  = 1'b1;
              state_nx = P_IDLE;
            end else begin
              addr_nx  = addr + 4'd1;
              state_nx = P_HI;
            end
          end else begin
            fail = 1'b1;
          end
        end
        default: state_nx = P_IDLE;
      endcase
    end
    if (fail) begin
      err_nx   = 1'b1;
      hold_nx  = 1'b0;
      state_nx = P_IDLE;
    end
  end

endmodule

// File: tb/tb_td4_uart_loader.sv
// Directed bench for the TD4 serial loader with a write monitor and per-scenario checks.
module tb_td4_uart_loader;

  localparam int CPB = 8;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       fpga_rx = 1'b1;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       cpu_hold;
  logic       load_done;
  logic       load_err;

  int total = 0;
  int bad = 0;

  logic [3:0] mon_addr[$];
  logic [7:0] mon_data[$];
  int         done_cnt = 0;
  logic       done_with_wr = 1'b0;
  logic       hold_at_done = 1'b0;
  logic       hold_after_done = 1'b1;
  logic       done_prev = 1'b0;

  logic [7:0] full_img [16] = '{8'hB3, 8'h01, 8'hE1, 8'hF0, 8'h10, 8'h20, 8'h30, 8'h40,
                                8'h5A, 8'h6B, 8'h7C, 8'h8D, 8'h9E, 8'hAF, 8'hC5, 8'hD6};

  td4_uart_loader #(.CLKS_PER_BIT(CPB)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .fpga_rx   (fpga_rx),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  // 100 MHz-style free-running clock for simulation.
  always #5 clock = ~clock;

  // Write monitor sampled just after each rising edge.
  always @(posedge clock) begin
    #1;
    if (wr_en) begin
      mon_addr.push_back(wr_addr);
      mon_data.push_back(wr_data);
    end
    if (done_prev) hold_after_done = cpu_hold;
    if (load_done) begin
      done_cnt++;
      done_with_wr = wr_en;
      hold_at_done = cpu_hold;
    end
    done_prev = load_done;
  end

  task automatic clear_mon();
    mon_addr.delete();
    mon_data.delete();
    done_cnt = 0;
    done_with_wr = 1'b0;
    hold_at_done = 1'b0;
    hold_after_done = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    fpga_rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      fpga_rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    fpga_rx = stop;
    repeat (CPB) @(negedge clock);
    fpga_rx = 1'b1;
  endtask

  function automatic logic [7:0] nib_ch(input logic [3:0] n, input logic lower);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return (lower ? 8'h57 : 8'h37) + {4'h0, n};
  endfunction

  task automatic send_hex(input logic [7:0] v, input logic lower);
    send_byte(nib_ch(v[7:4], lower), 1'b1);
    send_byte(nib_ch(v[3:0], lower), 1'b1);
  endtask

  task automatic test_reset();
    idle(3);
    total += 6;
    if (wr_en !== 1'b0)     begin bad++; $display("[TB] FAIL rst_wr_en got=%b want=0", wr_en); end
    if (wr_addr !== 4'd0)   begin bad++; $display("[TB] FAIL rst_wr_addr got=%h want=0", wr_addr); end
    if (wr_data !== 8'd0)   begin bad++; $display("[TB] FAIL rst_wr_data got=%h want=00", wr_data); end
    if (cpu_hold !== 1'b0)  begin bad++; $display("[TB] FAIL rst_cpu_hold got=%b want=0", cpu_hold); end
    if (load_done !== 1'b0) begin bad++; $display("[TB] FAIL rst_load_done got=%b want=0", load_done); end
    if (load_err !== 1'b0)  begin bad++; $display("[TB] FAIL rst_load_err got=%b want=0", load_err); end
    reset_n = 1'b1;
    idle(20);
  endtask

  task automatic test_full_load();
    clear_mon();
    send_byte(8'h40, 1'b1);
    total++;
    if (cpu_hold !== 1'b1) begin bad++; $display("[TB] FAIL full_hold_at got=%b want=1", cpu_hold); end
    for (int i = 0; i < 16; i++) begin
      send_hex(full_img[i], 1'b0);
      if (i != 15) send_byte(8'h20, 1'b1);
    end
    idle(4);
    total++;
    if (mon_addr.size() !== 16) begin bad++; $display("[TB] FAIL full_count got=%0d want=16", mon_addr.size()); end
    for (int i = 0; i < 16 && i < mon_addr.size(); i++) begin
      total += 2;
      if (mon_addr[i] !== 4'(i)) begin bad++; $display("[TB] FAIL full_addr%0d got=%h want=%h", i, mon_addr[i], 4'(i)); end
      if (mon_data[i] !== full_img[i]) begin bad++; $display("[TB] FAIL full_data%0d got=%h want=%h", i, mon_data[i], full_img[i]); end
    end
    total += 6;
    if (done_cnt !== 1)           begin bad++; $display("[TB] FAIL full_done_cnt got=%0d want=1", done_cnt); end
    if (done_with_wr !== 1'b1)    begin bad++; $display("[TB] FAIL full_done_with_wr got=%b want=1", done_with_wr); end
    if (hold_at_done !== 1'b1)    begin bad++; $display("[TB] FAIL full_hold_at_done got=%b want=1", hold_at_done); end
    if (hold_after_done !== 1'b0) begin bad++; $display("[TB] FAIL full_hold_after got=%b want=0", hold_after_done); end
    if (load_err !== 1'b0)        begin bad++; $display("[TB] FAIL full_err got=%b want=0", load_err); end
    if (cpu_hold !== 1'b0)        begin bad++; $display("[TB] FAIL full_hold_end got=%b want=0", cpu_hold); end
  endtask

  task automatic test_lowercase();
    clear_mon();
    send_byte(8'h40, 1'b1);
    send_byte(8'h62, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h0D, 1'b1);
    send_byte(8'h0A, 1'b1);
    send_byte(8'h30, 1'b1);
    send_byte(8'h61, 1'b1);
    idle(4);
    total += 3;
    if (mon_data.size() !== 2) begin bad++; $display("[TB] FAIL lc_count got=%0d want=2", mon_data.size()); end
    if (load_err !== 1'b0)     begin bad++; $display("[TB] FAIL lc_err got=%b want=0", load_err); end
    if (cpu_hold !== 1'b1)     begin bad++; $display("[TB] FAIL lc_hold got=%b want=1", cpu_hold); end
    if (mon_data.size() == 2) begin
      total += 3;
      if (mon_data[0] !== 8'hB3) begin bad++; $display("[TB] FAIL lc_data0 got=%h want=b3", mon_data[0]); end
      if (mon_data[1] !== 8'h0A) begin bad++; $display("[TB] FAIL lc_data1 got=%h want=0a", mon_data[1]); end
      if (mon_addr[1] !== 4'd1)  begin bad++; $display("[TB] FAIL lc_addr1 got=%h want=1", mon_addr[1]); end
    end
  endtask

  task automatic test_invalid_char();
    clear_mon();
    send_byte(8'h40, 1'b1);
    send_hex(8'h12, 1'b0);
    send_hex(8'h34, 1'b0);
    send_hex(8'h56, 1'b0);
    send_byte(8'h47, 1'b1);
    idle(4);
    total += 4;
    if (mon_data.size() !== 3) begin bad++; $display("[TB] FAIL inv_count got=%0d want=3", mon_data.size()); end
    if (load_err !== 1'b1)     begin bad++; $display("[TB] FAIL inv_err got=%b want=1", load_err); end
    if (cpu_hold !== 1'b0)     begin bad++; $display("[TB] FAIL inv_hold got=%b want=0", cpu_hold); end
    if (done_cnt !== 0)        begin bad++; $display("[TB] FAIL inv_done got=%0d want=0", done_cnt); end
    if (mon_data.size() == 3) begin
      total++;
      if (mon_data[2] !== 8'h56) begin bad++; $display("[TB] FAIL inv_data2 got=%h want=56", mon_data[2]); end
    end
    clear_mon();
    send_byte(8'h40, 1'b1);
    total += 2;
    if (load_err !== 1'b0) begin bad++; $display("[TB] FAIL inv_reat_err got=%b want=0", load_err); end
    if (cpu_hold !== 1'b1) begin bad++; $display("[TB] FAIL inv_reat_hold got=%b want=1", cpu_hold); end
    send_hex(8'h77, 1'b0);
    idle(4);
    total++;
    if (mon_data.size() !== 1) begin bad++; $display("[TB] FAIL inv_re_count got=%0d want=1", mon_data.size()); end
    if (mon_data.size() == 1) begin
      total += 2;
      if (mon_addr[0] !== 4'd0)  begin bad++; $display("[TB] FAIL inv_re_addr got=%h want=0", mon_addr[0]); end
      if (mon_data[0] !== 8'h77) begin bad++; $display("[TB] FAIL inv_re_data got=%h want=77", mon_data[0]); end
    end
  endtask

  task automatic test_framing();
    clear_mon();
    send_byte(8'h40, 1'b1);
    send_hex(8'h11, 1'b0);
    send_hex(8'h22, 1'b0);
    send_hex(8'h33, 1'b0);
    send_hex(8'h44, 1'b0);
    send_byte(8'h35, 1'b0);
    idle(2 * CPB);
    send_byte(8'h35, 1'b1);
    idle(4);
    total += 3;
    if (mon_data.size() !== 4) begin bad++; $display("[TB] FAIL fe_count got=%0d want=4", mon_data.size()); end
    if (load_err !== 1'b1)     begin bad++; $display("[TB] FAIL fe_err got=%b want=1", load_err); end
    if (cpu_hold !== 1'b0)     begin bad++; $display("[TB] FAIL fe_hold got=%b want=0", cpu_hold); end
    reset_n = 1'b0;
    idle(3);
    reset_n = 1'b1;
    idle(4);
    clear_mon();
    send_byte(8'h40, 1'b0);
    idle(2 * CPB);
    total += 3;
    if (load_err !== 1'b0)     begin bad++; $display("[TB] FAIL fe_idle_err got=%b want=0", load_err); end
    if (cpu_hold !== 1'b0)     begin bad++; $display("[TB] FAIL fe_idle_hold got=%b want=0", cpu_hold); end
    if (mon_data.size() !== 0) begin bad++; $display("[TB] FAIL fe_idle_count got=%0d want=0", mon_data.size()); end
  endtask

  task automatic test_glitch_split();
    clear_mon();
    send_byte(8'h40, 1'b1);
    fpga_rx = 1'b0;
    idle(3);
    fpga_rx = 1'b1;
    idle(12 * CPB);
    total += 3;
    if (load_err !== 1'b0)     begin bad++; $display("[TB] FAIL gl_err got=%b want=0", load_err); end
    if (cpu_hold !== 1'b1)     begin bad++; $display("[TB] FAIL gl_hold got=%b want=1", cpu_hold); end
    if (mon_data.size() !== 0) begin bad++; $display("[TB] FAIL gl_count got=%0d want=0", mon_data.size()); end
    send_byte(8'h42, 1'b1);
    send_byte(8'h20, 1'b1);
    send_byte(8'h33, 1'b1);
    idle(4);
    total += 3;
    if (load_err !== 1'b1)     begin bad++; $display("[TB] FAIL sp_err got=%b want=1", load_err); end
    if (cpu_hold !== 1'b0)     begin bad++; $display("[TB] FAIL sp_hold got=%b want=0", cpu_hold); end
    if (mon_data.size() !== 0) begin bad++; $display("[TB] FAIL sp_count got=%0d want=0", mon_data.size()); end
  endtask

  task automatic test_reset_mid_load();
    clear_mon();
    send_byte(8'h40, 1'b1);
    for (int i = 0; i < 7; i++) send_hex(full_img[i + 8], 1'b0);
    idle(2);
    total++;
    if (mon_data.size() !== 7) begin bad++; $display("[TB] FAIL rm_count got=%0d want=7", mon_data.size()); end
    reset_n = 1'b0;
    #1;
    total += 6;
    if (wr_en !== 1'b0)     begin bad++; $display("[TB] FAIL rm_wr_en got=%b want=0", wr_en); end
    if (wr_addr !== 4'd0)   begin bad++; $display("[TB] FAIL rm_wr_addr got=%h want=0", wr_addr); end
    if (wr_data !== 8'd0)   begin bad++; $display("[TB] FAIL rm_wr_data got=%h want=00", wr_data); end
    if (cpu_hold !== 1'b0)  begin bad++; $display("[TB] FAIL rm_cpu_hold got=%b want=0", cpu_hold); end
    if (load_done !== 1'b0) begin bad++; $display("[TB] FAIL rm_load_done got=%b want=0", load_done); end
    if (load_err !== 1'b0)  begin bad++; $display("[TB] FAIL rm_load_err got=%b want=0", load_err); end
    idle(3);
    reset_n = 1'b1;
    idle(4);
    clear_mon();
    send_hex(8'h9E, 1'b0);
    send_hex(8'hAF, 1'b0);
    idle(4);
    total += 2;
    if (mon_data.size() !== 0) begin bad++; $display("[TB] FAIL rm_after_count got=%0d want=0", mon_data.size()); end
    if (cpu_hold !== 1'b0)     begin bad++; $display("[TB] FAIL rm_after_hold got=%b want=0", cpu_hold); end
    send_byte(8'h40, 1'b1);
    send_hex(8'h5C, 1'b0);
    idle(4);
    total++;
    if (mon_data.size() !== 1) begin bad++; $display("[TB] FAIL rm_new_count got=%0d want=1", mon_data.size()); end
    if (mon_data.size() == 1) begin
      total += 2;
      if (mon_addr[0] !== 4'd0)  begin bad++; $display("[TB] FAIL rm_new_addr got=%h want=0", mon_addr[0]); end
      if (mon_data[0] !== 8'h5C) begin bad++; $display("[TB] FAIL rm_new_data got=%h want=5c", mon_data[0]); end
    end
  endtask

  // Scenario sequence; every stimulus edge is aligned to the falling clock edge.
  initial begin
    @(negedge clock);
    test_reset();
    test_full_load();
    test_lowercase();
    test_invalid_char();
    test_framing();
    test_glitch_split();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
